// File: rtl/qpsk_map_if.sv
// Byte-in / IQ-sample-out handshake bundle for the QPSK mapper.
// The slave side is the mapper; the master side feeds bytes and sinks samples.
interface qpsk_map_if #(
  parameter int WORD_LENGTH = 16
);
  logic                          in_vld;
  logic [7:0]                    in_data;
  logic                          in_rdy;
  logic                          out_rdy;
  logic                          out_vld;
  logic signed [WORD_LENGTH-1:0] out_real;
  logic signed [WORD_LENGTH-1:0] out_imag;
  logic                          out_sop;
  logic                          out_eop;

  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_real, out_imag, out_sop, out_eop
  );

  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_real, out_imag, out_sop, out_eop
  );
endinterface

// File: rtl/qpsk_map.sv
// TX QPSK mapper: unpacks bytes MSB-first into 2-bit symbols and emits +/-AMP I/Q
// samples framed into N_FFT-sample OFDM symbols with sop/eop markers.
module qpsk_map #(
  parameter int WORD_LENGTH = 16,
  parameter int AMP         = 5793,
  parameter int N_FFT       = 64
) (
  input logic       clk,
  input logic       rst_n,
  qpsk_map_if.slave bus
);
  localparam int IDX_W = $clog2(N_FFT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FFT - 1);
  localparam logic signed [WORD_LENGTH-1:0] AMP_S = WORD_LENGTH'(AMP);

  if (AMP <= 0 || AMP >= (1 << (WORD_LENGTH - 1)) || N_FFT < 4 || (N_FFT & (N_FFT - 1)) != 0)
  begin : g_bad_params
    $error("qpsk_map: AMP or N_FFT out of range");
  end

  // A set bit selects the negative point, matching qpsk_demap's hard decision.
  function automatic logic signed [WORD_LENGTH-1:0] map_axis(input logic bit_in);
    return bit_in ? -AMP_S : AMP_S;
  endfunction

  logic [7:0]                    buf_p0;
  logic [2:0]                    cnt_p0;
  logic signed [WORD_LENGTH-1:0] real_p1;
  logic signed [WORD_LENGTH-1:0] imag_p1;
  logic                          vld_p1;
  logic [IDX_W-1:0]              idx_p1;
  logic                          load;
  logic                          accept;
  logic                          in_rdy;

  always_comb begin
    load   = (cnt_p0 != 3'd0) && (!vld_p1 || bus.out_rdy);
    in_rdy = (cnt_p0 == 3'd0) || ((cnt_p0 == 3'd1) && load);
    accept = bus.in_vld && in_rdy;
  end

  // Stage A: byte buffer, top two bits are always the next symbol
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_p0 <= '0;
      cnt_p0 <= '0;
    end else if (accept) begin
      buf_p0 <= bus.in_data;
      cnt_p0 <= 3'd4;
    end else if (load) begin
      buf_p0 <= {buf_p0[5:0], 2'b00};
      cnt_p0 <= cnt_p0 - 3'd1;
    end
  end

  // Stage B: output sample register and frame position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      real_p1 <= '0;
      imag_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (load) begin
      real_p1 <= map_axis(buf_p0[7]);
      imag_p1 <= map_axis(buf_p0[6]);
      vld_p1  <= 1'b1;
    end else if (bus.out_rdy) begin
      vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_p1 <= '0;
    end else if (vld_p1 && bus.out_rdy) begin
      idx_p1 <= (idx_p1 == IDX_LAST) ? '0 : idx_p1 + IDX_W'(1);
    end
  end

  assign bus.in_rdy   = in_rdy;
  assign bus.out_vld  = vld_p1;
  assign bus.out_real = real_p1;
  assign bus.out_imag = imag_p1;
  assign bus.out_sop  = vld_p1 && (idx_p1 == '0);
  assign bus.out_eop  = vld_p1 && (idx_p1 == IDX_LAST);
endmodule

// File: tb/tb_qpsk_map.sv
// Randomized self-checking bench for qpsk_map against a symbol-level reference model.
module tb_qpsk_map;
  localparam int WL    = 16;
  localparam int AMP   = 5793;
  localparam int N_FFT = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  qpsk_map_if #(.WORD_LENGTH(WL)) bus ();

  qpsk_map #(.WORD_LENGTH(WL), .AMP(AMP), .N_FFT(N_FFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int   re;
    int   im;
    logic sop;
    logic eop;
    int   cyc;
  } obs_t;

  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   bp_mode = 0;  // 0: out_rdy=1, 1: random, 2: out_rdy=0
  obs_t obs_q[$];
  int   acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (bp_mode)
      1:       bus.out_rdy = 1'($urandom_range(0, 1));
      2:       bus.out_rdy = 1'b0;
      default: bus.out_rdy = 1'b1;
    endcase
  end

  // Record every handshake that the upcoming rising edge will complete.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1)
        obs_q.push_back(obs_t'{int'(bus.out_real), int'(bus.out_imag), bus.out_sop, bus.out_eop, cyc + 1});
      if (bus.in_vld === 1'b1 && bus.in_rdy === 1'b1)
        acc_q.push_back(cyc + 1);
    end
  end

  // Reference model: symbol k of byte b, MSB pair first; a set bit means negative.
  function automatic int exp_re(input logic [7:0] b, input int k);
    int sym;
    sym = (int'(b) >> (6 - 2 * k)) % 4;
    return (sym >= 2) ? -AMP : AMP;
  endfunction

  function automatic int exp_im(input logic [7:0] b, input int k);
    int sym;
    sym = (int'(b) >> (6 - 2 * k)) % 4;
    return (sym % 2 == 1) ? -AMP : AMP;
  endfunction

  task automatic do_reset();
    bus.in_vld = 1'b0;
    bp_mode    = 0;
    #1 rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n   = 1'b1;
    obs_q.delete();
    acc_q.delete();
  endtask

  // gap < 0 picks a random 0..2 idle cycles after each byte.
  task automatic drive_bytes(input logic [7:0] q[$], input int gap);
    int g;
    int t;
    @(posedge clk); #1;
    foreach (q[i]) begin
      bus.in_vld  = 1'b1;
      bus.in_data = q[i];
      t = 0;
      @(negedge clk);
      while (bus.in_rdy !== 1'b1 && t < 200) begin
        t++;
        @(negedge clk);
      end
      @(posedge clk); #1;
      bus.in_vld  = 1'b0;
      bus.in_data = 8'($urandom);
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_samples(input int n, input int max_cycles);
    int t;
    t = 0;
    while (obs_q.size() < n && t < max_cycles) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_vld  = 1'b0;
    bus.in_data = 8'h00;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b want 0", bus.out_vld); end
    checks++; if (bus.out_real !== 16'sd0) begin errors++; $display("FAIL reset_out_real: got %0d want 0", bus.out_real); end
    checks++; if (bus.out_imag !== 16'sd0) begin errors++; $display("FAIL reset_out_imag: got %0d want 0", bus.out_imag); end
    checks++; if (bus.out_sop !== 1'b0 || bus.out_eop !== 1'b0) begin errors++; $display("FAIL reset_sop_eop: got %b%b want 00", bus.out_sop, bus.out_eop); end
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b want 1", bus.in_rdy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_rdy !== 1'b1 || bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_release: got in_rdy=%b out_vld=%b want 1/0", bus.in_rdy, bus.out_vld); end
  endtask

  task automatic test_single();
    logic [7:0] q[$];
    do_reset();
    q = '{8'h1B};
    drive_bytes(q, 0);
    wait_samples(4, 50);
    checks++; if (obs_q.size() != 4 || acc_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d samples %0d bytes want 4/1", obs_q.size(), acc_q.size()); end
    for (int k = 0; k < 4 && k < obs_q.size() && acc_q.size() > 0; k++) begin
      checks++;
      if (obs_q[k].re !== exp_re(q[0], k) || obs_q[k].im !== exp_im(q[0], k)) begin
        errors++; $display("FAIL single_data[%0d]: got (%0d,%0d) want (%0d,%0d)", k, obs_q[k].re, obs_q[k].im, exp_re(q[0], k), exp_im(q[0], k));
      end
      checks++;
      if (obs_q[k].cyc !== acc_q[0] + 2 + k) begin
        errors++; $display("FAIL single_timing[%0d]: got edge %0d want %0d", k, obs_q[k].cyc, acc_q[0] + 2 + k);
      end
      checks++;
      if (obs_q[k].sop !== (k == 0) || obs_q[k].eop !== 1'b0) begin
        errors++; $display("FAIL single_frame[%0d]: got sop=%b eop=%b want %b/0", k, obs_q[k].sop, obs_q[k].eop, k == 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    do_reset();
    for (int i = 0; i < 17; i++) q.push_back(8'($urandom));
    drive_bytes(q, 0);
    wait_samples(68, 300);
    checks++; if (obs_q.size() != 68 || acc_q.size() != 17) begin errors++; $display("FAIL b2b_count: got %0d samples %0d bytes want 68/17", obs_q.size(), acc_q.size()); end
    for (int i = 1; i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] - acc_q[i-1] !== 4) begin errors++; $display("FAIL b2b_accept_gap[%0d]: got %0d want 4", i, acc_q[i] - acc_q[i-1]); end
    end
    for (int i = 0; i < obs_q.size() && i < 68; i++) begin
      checks++;
      if (obs_q[i].re !== exp_re(q[i/4], i%4) || obs_q[i].im !== exp_im(q[i/4], i%4)) begin
        errors++; $display("FAIL b2b_data[%0d]: got (%0d,%0d) want (%0d,%0d)", i, obs_q[i].re, obs_q[i].im, exp_re(q[i/4], i%4), exp_im(q[i/4], i%4));
      end
      checks++;
      if (obs_q[i].sop !== (i % N_FFT == 0) || obs_q[i].eop !== (i % N_FFT == N_FFT - 1)) begin
        errors++; $display("FAIL b2b_frame[%0d]: got sop=%b eop=%b want %b/%b", i, obs_q[i].sop, obs_q[i].eop, i % N_FFT == 0, i % N_FFT == N_FFT - 1);
      end
      checks++;
      if (obs_q[i].cyc !== obs_q[0].cyc + i) begin
        errors++; $display("FAIL b2b_contiguous[%0d]: got edge %0d want %0d", i, obs_q[i].cyc, obs_q[0].cyc + i);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] b;
    b = 8'hC6;
    do_reset();
    @(posedge clk); #1;
    bus.in_vld  = 1'b1;
    bus.in_data = b;
    @(negedge clk);
    @(posedge clk); #1;
    bus.in_vld  = 1'b0;
    bus.in_data = 8'h00;
    @(posedge clk);
    @(posedge clk); #1;
    bp_mode = 2;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++;
      if (bus.out_vld !== 1'b1 || int'(bus.out_real) !== exp_re(b, 1) || int'(bus.out_imag) !== exp_im(b, 1)) begin
        errors++; $display("FAIL stall_hold[%0d]: got vld=%b (%0d,%0d) want 1 (%0d,%0d)", s, bus.out_vld, bus.out_real, bus.out_imag, exp_re(b, 1), exp_im(b, 1));
      end
      checks++;
      if (bus.in_rdy !== 1'b0 || bus.out_sop !== 1'b0 || bus.out_eop !== 1'b0) begin
        errors++; $display("FAIL stall_ctrl[%0d]: got in_rdy=%b sop=%b eop=%b want 0/0/0", s, bus.in_rdy, bus.out_sop, bus.out_eop);
      end
      @(posedge clk);
    end
    #1 bp_mode = 0;
    wait_samples(4, 50);
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL stall_count: got %0d want 4", obs_q.size()); end
    for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].re !== exp_re(b, k) || obs_q[k].im !== exp_im(b, k)) begin
        errors++; $display("FAIL stall_data[%0d]: got (%0d,%0d) want (%0d,%0d)", k, obs_q[k].re, obs_q[k].im, exp_re(b, k), exp_im(b, k));
      end
    end
    if (obs_q.size() >= 2) begin
      checks++; if (obs_q[1].cyc - obs_q[0].cyc !== 4) begin errors++; $display("FAIL stall_length: got %0d want 4", obs_q[1].cyc - obs_q[0].cyc); end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] q[$];
    int bubbles;
    do_reset();
    for (int i = 0; i < 17; i++) q.push_back(8'($urandom));
    drive_bytes(q, 5);
    wait_samples(68, 400);
    checks++; if (obs_q.size() != 68) begin errors++; $display("FAIL gaps_count: got %0d want 68", obs_q.size()); end
    bubbles = 0;
    for (int i = 0; i < obs_q.size() && i < 68; i++) begin
      if (i > 0 && obs_q[i].cyc != obs_q[i-1].cyc + 1) bubbles++;
      checks++;
      if (obs_q[i].re !== exp_re(q[i/4], i%4) || obs_q[i].im !== exp_im(q[i/4], i%4)) begin
        errors++; $display("FAIL gaps_data[%0d]: got (%0d,%0d) want (%0d,%0d)", i, obs_q[i].re, obs_q[i].im, exp_re(q[i/4], i%4), exp_im(q[i/4], i%4));
      end
      checks++;
      if (obs_q[i].sop !== (i % N_FFT == 0) || obs_q[i].eop !== (i % N_FFT == N_FFT - 1)) begin
        errors++; $display("FAIL gaps_frame[%0d]: got sop=%b eop=%b want %b/%b", i, obs_q[i].sop, obs_q[i].eop, i % N_FFT == 0, i % N_FFT == N_FFT - 1);
      end
    end
    checks++; if (bubbles < 16) begin errors++; $display("FAIL gaps_bubbles: got %0d want >=16", bubbles); end
  endtask

  task automatic test_loopback();
    logic [7:0] q[$];
    int rb;
    do_reset();
    bp_mode = 1;
    for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
    drive_bytes(q, -1);
    wait_samples(1024, 20000);
    bp_mode = 0;
    checks++; if (obs_q.size() != 1024) begin errors++; $display("FAIL loop_count: got %0d want 1024", obs_q.size()); end
    for (int j = 0; j < 256 && 4 * j + 3 < obs_q.size(); j++) begin
      rb = 0;
      for (int k = 0; k < 4; k++)
        rb = rb * 4 + ((obs_q[4*j+k].re < 0) ? 2 : 0) + ((obs_q[4*j+k].im < 0) ? 1 : 0);
      checks++;
      if (rb !== int'(q[j])) begin errors++; $display("FAIL loop_byte[%0d]: got %02h want %02h", j, rb, q[j]); end
    end
    for (int i = 0; i < obs_q.size() && i < 1024; i++) begin
      checks++;
      if ((obs_q[i].re != AMP && obs_q[i].re != -AMP) || (obs_q[i].im != AMP && obs_q[i].im != -AMP) ||
          obs_q[i].sop !== (i % N_FFT == 0) || obs_q[i].eop !== (i % N_FFT == N_FFT - 1)) begin
        errors++; $display("FAIL loop_sample[%0d]: got (%0d,%0d) sop=%b eop=%b want +/-%0d sop=%b eop=%b", i, obs_q[i].re, obs_q[i].im, obs_q[i].sop, obs_q[i].eop, AMP, i % N_FFT == 0, i % N_FFT == N_FFT - 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    int t;
    do_reset();
    q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    drive_bytes(q, 0);
    t = 0;
    while (obs_q.size() < 10 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    checks++; if (obs_q.size() != 10) begin errors++; $display("FAIL rstmid_pre: got %0d samples want 10", obs_q.size()); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_vld !== 1'b0 || bus.out_real !== 16'sd0 || bus.out_imag !== 16'sd0 || bus.out_sop !== 1'b0 || bus.out_eop !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got vld=%b (%0d,%0d) sop=%b eop=%b want all 0", bus.out_vld, bus.out_real, bus.out_imag, bus.out_sop, bus.out_eop);
    end
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_in_rdy: got %b want 1", bus.in_rdy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    obs_q.delete();
    acc_q.delete();
    q = '{8'($urandom)};
    drive_bytes(q, 0);
    wait_samples(4, 50);
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL rstmid_count: got %0d want 4", obs_q.size()); end
    for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].re !== exp_re(q[0], k) || obs_q[k].im !== exp_im(q[0], k) || obs_q[k].sop !== (k == 0) || obs_q[k].eop !== 1'b0) begin
        errors++; $display("FAIL rstmid_sample[%0d]: got (%0d,%0d) sop=%b eop=%b want (%0d,%0d) sop=%b eop=0", k, obs_q[k].re, obs_q[k].im, obs_q[k].sop, obs_q[k].eop, exp_re(q[0], k), exp_im(q[0], k), k == 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_vld  = 1'b0;
    bus.in_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_gaps();
    test_loopback();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
